// File: rtl/uart_tx_sched.sv
// uart_tx_sched: round-robin scheduler that lets N_REQ requesters share one
// UART transmitter. The scheduler picks a requester, latches its byte,
// starts the frame and waits for the frame to finish. It aborts the frame
// if the transmitter does not finish in time. It then holds an idle gap
// before the next frame.
//
// Parameters
//   N_REQ    number of requesters (2..8)
//   GAP_CYC  idle clocks enforced between frames (0 allowed)
//   TMO_CYC  clocks to wait for tx_done before the frame is aborted
//
// Ports
//   clk       clock, all logic on posedge
//   rst       synchronous active-high reset
//   req       per-requester transmit request (level)
//   req_data  byte of requester i at bits [8i+7:8i]
//   grant     one-hot pulse in the selection cycle: requester's byte accepted
//   tx_load   one-cycle pulse to transmitter: tx_data valid, start frame
//   tx_data   latched byte presented to transmitter
//   tx_done   one-cycle pulse from transmitter: stop bit complete
//   owner     index of requester currently being served
//   busy      high whenever the scheduler is not idle
//   tmo_err   one-cycle pulse when a frame is aborted on timeout
module uart_tx_sched #(
    parameter int N_REQ   = 4,
    parameter int GAP_CYC = 16,
    parameter int TMO_CYC = 4096
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic [N_REQ-1:0]           req,
    input  logic [8*N_REQ-1:0]         req_data,
    output logic [N_REQ-1:0]           grant,
    output logic                       tx_load,
    output logic [7:0]                 tx_data,
    input  logic                       tx_done,
    output logic [$clog2(N_REQ)-1:0]   owner,
    output logic                       busy,
    output logic                       tmo_err
);

    localparam int W  = $clog2(N_REQ);
    localparam int CW = $clog2(TMO_CYC + GAP_CYC + 1);

    localparam logic [CW-1:0] TMO_LAST = CW'(TMO_CYC - 1);
    localparam logic [CW-1:0] GAP_LAST = (GAP_CYC > 0) ? CW'(GAP_CYC - 1) : '0;

    typedef enum logic [1:0] {
        S_IDLE,
        S_LOAD,
        S_XMIT,
        S_GAP
    } state_t;

    state_t          state;
    logic [W-1:0]    ptr;
    logic [CW-1:0]   cnt;
    logic            tx_load_r;
    logic            tmo_err_r;
    logic            rst_q;

    logic            found;
    logic [W-1:0]    win;
    logic [W:0]      slot;
    logic            sel;
    logic [W-1:0]    next_ptr;

    // Round-robin search starting at ptr. slot is ptr+i reduced modulo
    // N_REQ; one extra bit holds the sum before the wrap.
    always_comb begin
        found = 1'b0;
        win   = '0;
        slot  = '0;
        for (int unsigned i = 0; i < N_REQ; i++) begin
            slot = {1'b0, ptr} + (W+1)'(i);
            if (slot >= (W+1)'(N_REQ)) begin
                slot = slot - (W+1)'(N_REQ);
            end
            if (!found && req[slot[W-1:0]]) begin
                found = 1'b1;
                win   = slot[W-1:0];
            end
        end
    end

    // rst_q blocks selection in the first cycle after reset, so that
    // neither grant nor tx_load can follow a reset directly.
    assign sel = (state == S_IDLE) && found && !rst_q;

    always_comb begin
        grant = '0;
        if (sel && !rst) begin
            grant[win] = 1'b1;
        end
    end

    assign next_ptr = (owner == W'(N_REQ - 1)) ? '0 : owner + 1'b1;

    // Outputs are also gated by rst so they are quiet in the reset cycle
    // itself, before the synchronous reset has taken effect.
    assign busy    = (state != S_IDLE) && !rst;
    assign tx_load = tx_load_r && !rst;
    assign tmo_err = tmo_err_r && !rst;

    always_ff @(posedge clk) begin
        if (rst) begin
            state     <= S_IDLE;
            ptr       <= '0;
            owner     <= '0;
            tx_data   <= '0;
            cnt       <= '0;
            tx_load_r <= 1'b0;
            tmo_err_r <= 1'b0;
            rst_q     <= 1'b1;
        end else begin
            rst_q     <= 1'b0;
            tx_load_r <= 1'b0;
            tmo_err_r <= 1'b0;
            case (state)
                S_IDLE: begin
                    if (sel) begin
                        tx_data <= req_data[{win, 3'b000} +: 8];
                        owner   <= win;
                        state   <= S_LOAD;
                    end
                end
                S_LOAD: begin
                    tx_load_r <= 1'b1;
                    cnt       <= '0;
                    state     <= S_XMIT;
                end
                S_XMIT: begin
                    // tx_done has priority over the timeout terminal count
                    if (tx_done) begin
                        ptr   <= next_ptr;
                        cnt   <= '0;
                        state <= (GAP_CYC > 0) ? S_GAP : S_IDLE;
                    end else if (cnt == TMO_LAST) begin
                        tmo_err_r <= 1'b1;
                        ptr       <= next_ptr;
                        cnt       <= '0;
                        state     <= S_IDLE;
                    end else begin
                        cnt <= cnt + 1'b1;
                    end
                end
                S_GAP: begin
                    if (cnt == GAP_LAST) begin
                        cnt   <= '0;
                        state <= S_IDLE;
                    end else begin
                        cnt <= cnt + 1'b1;
                    end
                end
                default: state <= S_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_uart_tx_sched.sv
// Directed bench for uart_tx_sched with N_REQ=4, GAP_CYC=16 and TMO_CYC=32.
// A vector table drives a sequence of round-robin frames. Hand-written
// sequences then cover the timeout, the tx_done/timeout collision, stray
// tx_done pulses and a reset during transmission.
module tb_uart_tx_sched;

    logic        clk;
    logic        rst;
    logic [3:0]  req;
    logic [31:0] req_data;
    logic [3:0]  grant;
    logic        tx_load;
    logic [7:0]  tx_data;
    logic        tx_done;
    logic [1:0]  owner;
    logic        busy;
    logic        tmo_err;

    int checks   = 0;
    int failures = 0;
    int cyc      = 0;

    uart_tx_sched #(
        .N_REQ   (4),
        .GAP_CYC (16),
        .TMO_CYC (32)
    ) dut (
        .clk      (clk),
        .rst      (rst),
        .req      (req),
        .req_data (req_data),
        .grant    (grant),
        .tx_load  (tx_load),
        .tx_data  (tx_data),
        .tx_done  (tx_done),
        .owner    (owner),
        .busy     (busy),
        .tmo_err  (tmo_err)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    typedef struct {
        logic [3:0] r;
        int         w;
        logic [7:0] d;
        bit         drop;
    } vec_t;

    vec_t vecs[10];

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    // Apply a request and wait (bounded) for its grant. Check the grant,
    // then the LOAD cycle, then the tx_load cycle. Return at the tx_load cycle.
    task automatic start_frame(input logic [3:0] r, input int w, input logic [7:0] d,
                               input bit drop, output int gcyc);
        int n;
        n = 0;
        req = r;
        #1;
        while (grant == 4'b0000 && n < 60) begin
            tick();
            n++;
        end
        if (grant == 4'b0000) begin
            failures++;
            $display("FAIL grant_wait: no grant within 60 cycles (cycle %0d)", cyc);
        end
        chk("grant", 32'(grant), 32'(1) << w);
        gcyc = cyc;
        tick();
        // dropping req after the grant edge must not disturb the frame
        if (drop) req = '0;
        chk("load_no_txload", 32'(tx_load), 32'd0);
        chk("load_busy", 32'(busy), 32'd1);
        chk("load_no_grant", 32'(grant), 32'd0);
        tick();
        chk("txload", 32'(tx_load), 32'd1);
        chk("tx_data", 32'(tx_data), 32'(d));
        chk("owner", 32'(owner), 32'(w));
    endtask

    // From the tx_load cycle, pulse tx_done 'delay' cycles later. Return in
    // the first cycle after the pulse.
    task automatic finish_done(input int delay);
        repeat (delay) tick();
        tx_done = 1'b1;
        tick();
        tx_done = 1'b0;
        chk("gap_busy", 32'(busy), 32'd1);
        chk("done_no_tmo", 32'(tmo_err), 32'd0);
    endtask

    initial begin
        int g;
        int prev_g;
        int dcyc;
        int rcyc;

        // byte per requester: 0->A1, 1->3C, 2->5A, 3->D4
        req_data = {8'hD4, 8'h5A, 8'h3C, 8'hA1};
        req      = '0;
        tx_done  = 1'b0;
        rst      = 1'b1;
        prev_g   = 0;

        // Expected winners follow the pointer: start 0, then owner+1 after each frame.
        vecs[0] = '{4'b0100, 2, 8'h5A, 1'b0};
        vecs[1] = '{4'b1111, 3, 8'hD4, 1'b0};
        vecs[2] = '{4'b1111, 0, 8'hA1, 1'b0};
        vecs[3] = '{4'b1111, 1, 8'h3C, 1'b0};
        vecs[4] = '{4'b1111, 2, 8'h5A, 1'b0};
        vecs[5] = '{4'b1111, 3, 8'hD4, 1'b0};
        vecs[6] = '{4'b0110, 1, 8'h3C, 1'b0};
        vecs[7] = '{4'b0011, 0, 8'hA1, 1'b0};
        vecs[8] = '{4'b1001, 3, 8'hD4, 1'b0};
        vecs[9] = '{4'b0010, 1, 8'h3C, 1'b1};

        // reset state
        repeat (3) tick();
        chk("rst_busy", 32'(busy), 32'd0);
        chk("rst_grant", 32'(grant), 32'd0);
        chk("rst_txload", 32'(tx_load), 32'd0);
        chk("rst_tmo", 32'(tmo_err), 32'd0);
        rst = 1'b0;
        tick();
        chk("rst_tx_data", 32'(tx_data), 32'd0);
        chk("rst_owner", 32'(owner), 32'd0);
        chk("post_rst_busy", 32'(busy), 32'd0);

        // stray tx_done while idle
        tx_done = 1'b1;
        tick();
        tx_done = 1'b0;
        chk("idle_stray_busy", 32'(busy), 32'd0);
        chk("idle_stray_tmo", 32'(tmo_err), 32'd0);
        chk("idle_stray_grant", 32'(grant), 32'd0);

        // Round-robin frames. tx_done arrives in the 10th transmit cycle
        // (tx_load cycle counted as the 1st). Back-to-back grants are then
        // 2 + 9 + (GAP_CYC+1) = 28 cycles apart.
        for (int i = 0; i < 10; i++) begin
            start_frame(vecs[i].r, vecs[i].w, vecs[i].d, vecs[i].drop, g);
            if (i > 0) chk("rr_spacing", 32'(g - prev_g), 32'd28);
            prev_g = g;
            finish_done(9);
        end

        // timeout: pointer is 2, only requester 0 asks
        start_frame(4'b0001, 0, 8'hA1, 1'b0, g);
        req = 4'b0011;
        repeat (31) tick();
        chk("tmo_not_yet", 32'(tmo_err), 32'd0);
        chk("tmo_busy_before", 32'(busy), 32'd1);
        tick();
        chk("tmo_pulse", 32'(tmo_err), 32'd1);
        chk("tmo_busy_fall", 32'(busy), 32'd0);
        chk("tmo_next_grant", 32'(grant), 32'b0010);
        tick();
        chk("tmo_one_cycle", 32'(tmo_err), 32'd0);
        chk("tmo_reload_busy", 32'(busy), 32'd1);
        tick();
        chk("tmo2_txload", 32'(tx_load), 32'd1);
        chk("tmo2_owner", 32'(owner), 32'd1);
        chk("tmo2_tx_data", 32'(tx_data), 32'h3C);

        // collision: tx_done exactly on the timeout terminal cycle
        repeat (31) tick();
        dcyc = cyc;
        tx_done = 1'b1;
        tick();
        tx_done = 1'b0;
        chk("coll_no_tmo", 32'(tmo_err), 32'd0);
        chk("coll_gap_busy", 32'(busy), 32'd1);

        // stray tx_done during the gap must not restart it
        tx_done = 1'b1;
        tick();
        tx_done = 1'b0;
        chk("gap_stray_busy", 32'(busy), 32'd1);
        chk("gap_stray_tmo", 32'(tmo_err), 32'd0);
        chk("gap_stray_grant", 32'(grant), 32'd0);
        start_frame(4'b0011, 0, 8'hA1, 1'b0, g);
        chk("done_to_grant", 32'(g - dcyc), 32'd17);

        // reset during transmission, with requests 0 and 3 pending
        repeat (3) tick();
        req = 4'b1001;
        rst = 1'b1;
        #1;
        chk("mid_rst_busy", 32'(busy), 32'd0);
        chk("mid_rst_grant", 32'(grant), 32'd0);
        chk("mid_rst_txload", 32'(tx_load), 32'd0);
        rcyc = cyc;
        tick();
        rst = 1'b0;
        #1;
        chk("after_rst_busy", 32'(busy), 32'd0);
        chk("after_rst_grant", 32'(grant), 32'd0);
        chk("after_rst_txload", 32'(tx_load), 32'd0);
        chk("after_rst_owner", 32'(owner), 32'd0);
        chk("after_rst_tx_data", 32'(tx_data), 32'd0);
        // pointer back at 0, so requester 0 wins over 3
        start_frame(4'b1001, 0, 8'hA1, 1'b0, g);
        chk("rst_to_grant", 32'(g - rcyc), 32'd2);
        finish_done(5);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
